// File: rtl/mac_pkg.sv
// Width arithmetic and saturation bounds shared by the streaming MAC blocks.
package mac_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int prod_w(input int data_w, input int weight_w);
    return data_w + weight_w;
  endfunction

  function automatic int lsum_w(input int data_w, input int weight_w, input int lanes);
    return prod_w(data_w, weight_w) + clog2(lanes);
  endfunction

  // Sized so a full window of worst-case products cannot wrap.
  function automatic int acc_w(input int data_w, input int weight_w, input int lanes,
                               input int acc_len);
    return data_w + weight_w + clog2(lanes * acc_len);
  endfunction

  function automatic int cnt_w(input int acc_len);
    return (acc_len > 1) ? clog2(acc_len) : 1;
  endfunction

  function automatic longint sat_hi(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational signed multiplier array and lossless lane adder for one beat.
module mac_lane_sum
  import mac_pkg::*;
#(
  parameter int LANES    = 3,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  localparam int PROD_W  = prod_w(DATA_W, WEIGHT_W),
  localparam int LSUM_W  = lsum_w(DATA_W, WEIGHT_W, LANES)
) (
  input  logic [LANES*DATA_W-1:0]   data,
  input  logic [LANES*WEIGHT_W-1:0] weight,
  output logic signed [LSUM_W-1:0]  lane_sum
);

  logic signed [LSUM_W-1:0] prod_ext [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [PROD_W-1:0] prod;
    assign prod = $signed(data[gi*DATA_W +: DATA_W]) * $signed(weight[gi*WEIGHT_W +: WEIGHT_W]);
    assign prod_ext[gi] = LSUM_W'(prod);
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + prod_ext[i];
  end

endmodule

// File: rtl/mac_stream.sv
// Flow-controlled MAC: accumulates ACC_LEN beats, then rounds, shifts and
// saturates the window sum into a registered valid/ready output.
module mac_stream
  import mac_pkg::*;
#(
  parameter int LANES    = 3,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_LEN  = 3,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*WEIGHT_W-1:0] in_weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat
);

  localparam int LSUM_W = lsum_w(DATA_W, WEIGHT_W, LANES);
  localparam int ACC_W  = acc_w(DATA_W, WEIGHT_W, LANES, ACC_LEN);
  localparam int CNT_W  = cnt_w(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  logic [CNT_W-1:0]         cnt, eff_cnt;
  logic signed [ACC_W-1:0]  acc, eff_acc, total;
  logic signed [LSUM_W-1:0] lane_sum;
  logic signed [ACC_W:0]    total_ext, rounded;
  logic signed [OUT_W-1:0]  sat_data;
  logic                     sat_flag, accept, last_beat;

  mac_lane_sum #(
    .LANES(LANES), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)
  ) u_lane_sum (
    .data(in_data), .weight(in_weight), .lane_sum(lane_sum)
  );

  // Only the closing beat can stall: it needs the output register free.
  assign in_ready  = !((cnt == LAST) && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  // A beat arriving with clear is beat 0 of a fresh window.
  assign eff_cnt   = clear ? '0 : cnt;
  assign eff_acc   = clear ? '0 : acc;
  assign last_beat = accept && (eff_cnt == LAST);
  assign total     = eff_acc + ACC_W'(lane_sum);
  assign total_ext = (ACC_W+1)'(total);

  if (SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
    assign rounded = (total_ext + HALF) >>> SHIFT;
  end else begin : g_no_round
    assign rounded = total_ext;
  end

  if (OUT_W > ACC_W) begin : g_wide
    assign sat_data = OUT_W'(rounded);
    assign sat_flag = 1'b0;
  end else begin : g_clamp
    localparam logic signed [OUT_W-1:0] OUT_MAX = OUT_W'(sat_hi(OUT_W));
    localparam logic signed [OUT_W-1:0] OUT_MIN = OUT_W'(sat_lo(OUT_W));
    logic [ACC_W-OUT_W+1:0] hi;
    logic pos_ovf, neg_ovf;
    // Fits only when every bit above the output sign bit matches it.
    assign hi       = rounded[ACC_W:OUT_W-1];
    assign pos_ovf  = !rounded[ACC_W] && (|hi);
    assign neg_ovf  = rounded[ACC_W] && !(&hi);
    assign sat_data = pos_ovf ? OUT_MAX : (neg_ovf ? OUT_MIN : rounded[OUT_W-1:0]);
    assign sat_flag = pos_ovf || neg_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) begin
        if (last_beat) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= total;
          cnt <= eff_cnt + CNT_W'(1);
        end
      end else if (clear) begin
        acc <= '0;
        cnt <= '0;
      end
      if (last_beat) begin
        out_valid <= 1'b1;
        out_data  <= sat_data;
        out_sat   <= sat_flag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_stream.sv
// Self-checking bench: three MAC variants (default, OUT_W=16, SHIFT=4) share one stimulus stream.
module tb_mac_stream;
  localparam int L  = 3;
  localparam int DW = 8;
  localparam int AL = 3;

  logic clk = 1'b0;
  logic reset = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [L*DW-1:0] in_data = '0, in_weight = '0;

  logic in_ready_a, in_ready_b, in_ready_c;
  logic out_valid_a, out_valid_b, out_valid_c;
  logic out_sat_a, out_sat_b, out_sat_c;
  logic [19:0] out_data_a, out_data_c;
  logic [15:0] out_data_b;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    longint a; bit sa;
    longint b; bit sb;
    longint c; bit sc;
  } exp_t;
  exp_t q[$];

  int     m_cnt = 0;
  longint m_acc = 0;
  bit     m_ov  = 1'b0;

  always #5 clk = ~clk;

  mac_stream dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_sat(out_sat_a)
  );
  mac_stream #(.OUT_W(16)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_sat(out_sat_b)
  );
  mac_stream #(.SHIFT(4)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .out_sat(out_sat_c)
  );

  function automatic longint norm(input longint t, input int sh);
    if (sh > 0) return (t + (longint'(1) <<< (sh - 1))) >>> sh;
    return t;
  endfunction

  function automatic longint clamp_val(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic bit clamp_flag(input longint v, input int w);
    return (clamp_val(v, w) != v);
  endfunction

  function automatic longint bus_sum();
    longint s;
    s = 0;
    for (int i = 0; i < L; i++)
      s += longint'($signed(in_data[i*DW +: DW])) * longint'($signed(in_weight[i*DW +: DW]));
    return s;
  endfunction

  function automatic bit model_ready();
    return !((m_cnt == AL - 1) && m_ov && !out_ready);
  endfunction

  // Reference model, advanced once per rising edge from the stimulus it sees.
  task automatic model_step();
    bit rdy, take, fin;
    longint acc_e, s;
    int cnt_e;
    exp_t e;
    if (reset) begin
      m_cnt = 0; m_acc = 0; m_ov = 1'b0;
      q.delete();
      return;
    end
    rdy   = model_ready();
    acc_e = clear ? 0 : m_acc;
    cnt_e = clear ? 0 : m_cnt;
    take  = in_valid && rdy;
    fin   = take && (cnt_e == AL - 1);
    if (m_ov && out_ready && q.size() > 0) begin
      e = q.pop_front();
      $display("xfer a=%0d/%0d b=%0d/%0d c=%0d/%0d", e.a, e.sa, e.b, e.sb, e.c, e.sc);
    end
    if (take) begin
      s = acc_e + bus_sum();
      if (fin) begin
        e.a = clamp_val(norm(s, 0), 20); e.sa = clamp_flag(norm(s, 0), 20);
        e.b = clamp_val(norm(s, 0), 16); e.sb = clamp_flag(norm(s, 0), 16);
        e.c = clamp_val(norm(s, 4), 20); e.sc = clamp_flag(norm(s, 4), 20);
        q.push_back(e);
        m_acc = 0; m_cnt = 0;
      end else begin
        m_acc = s; m_cnt = cnt_e + 1;
      end
    end else if (clear) begin
      m_acc = 0; m_cnt = 0;
    end
    if (fin) m_ov = 1'b1;
    else if (out_ready) m_ov = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard compare on the falling edge, away from register updates.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      checks++;
      if ({out_valid_a, out_valid_b, out_valid_c} !== {3{m_ov}}) begin
        failures++;
        $display("FAIL sb_valid got=%b%b%b exp=%b", out_valid_a, out_valid_b, out_valid_c, m_ov);
      end
      if (m_ov && q.size() > 0) begin
        checks++;
        if (out_data_a !== 20'(q[0].a) || out_sat_a !== q[0].sa ||
            out_data_b !== 16'(q[0].b) || out_sat_b !== q[0].sb ||
            out_data_c !== 20'(q[0].c) || out_sat_c !== q[0].sc) begin
          failures++;
          $display("FAIL sb_data got a=%0d/%0d b=%0d/%0d c=%0d/%0d exp a=%0d/%0d b=%0d/%0d c=%0d/%0d",
                   $signed(out_data_a), out_sat_a, $signed(out_data_b), out_sat_b,
                   $signed(out_data_c), out_sat_c,
                   q[0].a, q[0].sa, q[0].b, q[0].sb, q[0].c, q[0].sc);
        end
      end
    end
  end

  task automatic set_lanes(input int d, input int w, input bit lane0_only);
    for (int i = 0; i < L; i++) begin
      in_data[i*DW +: DW]   = (lane0_only && i != 0) ? '0 : DW'(d);
      in_weight[i*DW +: DW] = (lane0_only && i != 0) ? '0 : DW'(w);
    end
  endtask

  task automatic send_beat(input int d, input int w, input bit lane0_only, input bit clr);
    int t;
    @(negedge clk);
    set_lanes(d, w, lane0_only);
    in_valid = 1'b1;
    clear = clr;
    t = 0;
    while (!model_ready() && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      failures++;
      $display("FAIL beat_timeout got=stalled exp=accepted");
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    set_lanes(0, 0, 1'b0);
  endtask

  task automatic window(input int d, input int w);
    for (int i = 0; i < AL; i++) send_beat(d, w, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    checks++;
    if (out_valid_a !== 1'b0 || out_data_a !== 20'd0 || out_sat_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%0d/%b exp=0/0/0", out_valid_a, out_data_a, out_sat_a);
    end
    checks++;
    if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready got=%b%b%b exp=111", in_ready_a, in_ready_b, in_ready_c);
    end
  endtask

  task automatic test_unit();
    window(1, 1);
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 20'd9 || out_sat_a !== 1'b0) begin
      failures++;
      $display("FAIL unit_window got=%b/%0d/%b exp=1/9/0", out_valid_a, out_data_a, out_sat_a);
    end
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL unit_pulse got=%b exp=0", out_valid_a);
    end
  endtask

  task automatic test_saturate();
    window(-128, -128);
    checks++;
    if (out_data_a !== 20'd147456 || out_sat_a !== 1'b0) begin
      failures++;
      $display("FAIL big_full got=%0d/%b exp=147456/0", out_data_a, out_sat_a);
    end
    checks++;
    if (out_data_b !== 16'd32767 || out_sat_b !== 1'b1) begin
      failures++;
      $display("FAIL big_sat16 got=%0d/%b exp=32767/1", out_data_b, out_sat_b);
    end
    checks++;
    if (out_data_c !== 20'd9216) begin
      failures++;
      $display("FAIL big_shift got=%0d exp=9216", out_data_c);
    end
  endtask

  task automatic test_shift();
    window(5, 1);
    checks++;
    if (out_data_c !== 20'd3 || out_data_a !== 20'd45) begin
      failures++;
      $display("FAIL shift_pos got=%0d/%0d exp=3/45", $signed(out_data_c), $signed(out_data_a));
    end
    window(-5, 1);
    checks++;
    if ($signed(out_data_c) !== -20'sd3 || out_sat_c !== 1'b0) begin
      failures++;
      $display("FAIL shift_neg got=%0d/%b exp=-3/0", $signed(out_data_c), out_sat_c);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * AL; i++) send_beat(i + 1, 2, 1'b0, 1'b0);
    idle();
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 20'd90) begin
      failures++;
      $display("FAIL b2b_second got=%b/%0d exp=1/90", out_valid_a, out_data_a);
    end
  endtask

  task automatic test_stall();
    window(1, 1);
    out_ready = 1'b0;
    set_lanes(2, 1, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    send_beat(2, 1, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== 20'd9) begin
        failures++;
        $display("FAIL stall_hold got=%b/%b/%0d exp=0/1/9", in_ready_a, out_valid_a, out_data_a);
      end
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got=%b exp=1", in_ready_a);
    end
    @(posedge clk);
    idle();
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 20'd18) begin
      failures++;
      $display("FAIL stall_window2 got=%b/%0d exp=1/18", out_valid_a, out_data_a);
    end
  endtask

  task automatic test_clear();
    send_beat(1, 1, 1'b0, 1'b0);
    send_beat(2, 1, 1'b0, 1'b1);
    send_beat(1, 1, 1'b0, 1'b0);
    send_beat(1, 1, 1'b0, 1'b0);
    idle();
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 20'd12) begin
      failures++;
      $display("FAIL clear_window got=%b/%0d exp=1/12", out_valid_a, out_data_a);
    end
  endtask

  task automatic test_mid_reset();
    send_beat(7, 3, 1'b0, 1'b0);
    send_beat(7, 3, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b exp=0/1", out_valid_a, in_ready_a);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < AL; i++) send_beat(1, 1, 1'b1, 1'b0);
    idle();
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 20'd3) begin
      failures++;
      $display("FAIL after_reset got=%b/%0d exp=1/3", out_valid_a, out_data_a);
    end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_saturate();
    test_shift();
    test_back_to_back();
    test_stall();
    test_clear();
    test_mid_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() > 1) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp<=1", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
